frame_update_sequencer: RTL and testbench
=========================================

# frame_update_sequencer

Schedules per-frame game-logic updates (paddle input, ball motion, collision, brick map) into the vertical-blanking window produced by the VGA timing generator. At each frame's blanking start it grants N_PH update phases strictly in order with a req/done handshake. It bounds each phase with a timeout and aborts the frame if blanking ends first, so the frame buffer state is never modified during active video.

## Interface
- N_PH, 4: number of update phases (2..8).
- VD, 480: first blanking line, i.e. the y value that starts the update window.
- TIMEOUT, 1000: maximum clk_100MHz cycles a phase may hold req before it is skipped (1..65535).
- clk_100MHz  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- p_tick  in  1  pixel-enable strobe from the timing generator, one clk_100MHz cycle in four.
- x  in  12  current pixel column.
- y  in  12  current pixel line.
- pause  in  1  when high at frame start, the frame's updates are skipped.
- ph_done  in  N_PH  per-phase completion; only the bit of the active phase is honoured.
- err_clr  in  1  clears the overrun flag and phase_err.
- ph_req  out  N_PH  one-hot phase request, held until done or timeout.
- busy  out  1  high whenever the state is not IDLE.
- frame_done  out  1  one-cycle pulse when all phases of a frame have been processed.
- frame_cnt  out  16  completed-frame counter, wraps 0xFFFF→0.
- overrun  out  1  sticky; frame aborted because active video restarted.
- overrun_cnt  out  8  aborted-frame count, saturates at 255.
- phase_err  out  N_PH  sticky per-phase timeout flags.

## Operation
- Events, evaluated only when p_tick=1:
  - start_ev when x==0 and y==VD.
  - abort_ev when x==0 and y==0.
- FSM states:
  - IDLE: on start_ev with pause=0, idx←0 and go to REQ. With pause=1, stay in IDLE.
  - REQ: ph_req[idx]=1 and tcnt increments every cycle.
    - ph_done[idx]=1 → GAP.
    - tcnt==TIMEOUT-1 with no done → phase_err[idx]←1, then GAP.
  - GAP: one cycle with ph_req=0 and tcnt←0.
    - If idx==N_PH-1 → FIN.
    - Otherwise idx←idx+1 and go to REQ.
  - FIN: frame_done=1 and frame_cnt←frame_cnt+1, then IDLE.
- abort_ev in REQ or GAP:
  - Next state is IDLE, ph_req drops next cycle.
  - overrun←1 and overrun_cnt←min(overrun_cnt+1,255).
  - frame_cnt unchanged; no frame_done.
- start_ev while not IDLE is ignored.
- Priority rules for simultaneous events:
  - Abort beats done and timeout.
  - Done beats timeout in the same cycle.
  - err_clr beats a concurrent set, so the flag ends cleared.
- ph_done bits other than the active phase, and any bits asserted in IDLE, GAP or FIN, are ignored.
- A timed-out phase still advances the sequence; the remaining phases run.

## Timing
- All outputs are registered. Reset values: ph_req=0, busy=0, frame_done=0, frame_cnt=0, overrun=0, overrun_cnt=0, phase_err=0, state IDLE, idx=0, tcnt=0.
- Reset assertion mid-sequence clears everything immediately and asynchronously. The first sequence after release starts at the next start_ev.
- start_ev sampled at edge k → ph_req[0]=1 from cycle k+1.
- ph_done[i] sampled at edge m → ph_req[i]=0 at m+1 (GAP); ph_req[i+1]=1 at m+2.
- Zero-wait phases (done high on the first req cycle) take 2 cycles each. The minimum frame, from start_ev to frame_done, is therefore 2·N_PH+1 cycles.
- Timeout: ph_req[i] is high for exactly TIMEOUT cycles, then GAP.
- frame_done and the frame_cnt increment appear in the same cycle (FIN).
- The blanking window at default timing is 45 lines × 800 px × 4 = 144000 cycles, which is the per-frame budget.

## Test plan
- Nominal frame: pause=0; each phase's done is returned 3 cycles after its req rises.
  - ph_req goes 0001→0010→0100→1000, each high for 3 cycles with a 1-cycle gap between.
  - frame_done pulses once; frame_cnt=1; busy low afterwards.
- Timeout: phase 2 never acknowledges.
  - ph_req[2] is high for exactly 1000 cycles, then phase_err=0100 and phase 3 still runs.
  - frame_cnt increments.
  - err_clr clears phase_err to 0.
- Overrun: phase 1 stalls with TIMEOUT=65535 until y wraps to 0.
  - At abort_ev, ph_req→0 next cycle; overrun=1, overrun_cnt=1, frame_cnt unchanged.
  - The next frame sequences normally.
- Pause and stray dones:
  - pause=1 at start_ev → no ph_req and frame_cnt unchanged for that frame.
  - ph_done=1111 held in IDLE has no effect.
  - ph_done[3] asserted during phase 0 does not advance the sequence.
- Simultaneous and reset: abort_ev coincides with ph_done[idx] → abort wins (overrun=1). Then reset_n is dropped mid-phase (async) → all outputs are 0 before the next clock edge. After release, the next start_ev begins phase 0.
- Saturation and wrap: force 300 aborted frames → overrun_cnt=255. Preload frame_cnt=0xFFFF via 65535 fast frames, or run a reduced-window frame → the next completed frame gives frame_cnt=0.

Source files
------------

// File: rtl/frame_update_sequencer.sv
// rtl/frame_update_sequencer.sv - sequences per-frame update phases inside vertical blanking
// Grants N_PH req/done phases in order at blanking start; aborts if active video restarts.
module frame_update_sequencer #(
  parameter int N_PH    = 4,
  parameter int VD      = 480,
  parameter int TIMEOUT = 1000
) (
  input  logic            clk_100MHz,
  input  logic            reset_n,
  input  logic            p_tick,
  input  logic [11:0]     x,
  input  logic [11:0]     y,
  input  logic            pause,
  input  logic [N_PH-1:0] ph_done,
  input  logic            err_clr,
  output logic [N_PH-1:0] ph_req,
  output logic            busy,
  output logic            frame_done,
  output logic [15:0]     frame_cnt,
  output logic            overrun,
  output logic [7:0]      overrun_cnt,
  output logic [N_PH-1:0] phase_err
);

  localparam int IW = (N_PH > 1) ? $clog2(N_PH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_GAP, S_FIN} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [15:0]     tcnt_q, tcnt_d;
  logic [N_PH-1:0] ph_req_q, ph_req_d;
  logic            busy_q, busy_d;
  logic            frame_done_q, frame_done_d;
  logic [15:0]     frame_cnt_q, frame_cnt_d;
  logic            overrun_q, overrun_d;
  logic [7:0]      overrun_cnt_q, overrun_cnt_d;
  logic [N_PH-1:0] phase_err_q, phase_err_d;

  logic start_ev, abort_ev;
  logic timeout_hit, abort_hit;

  assign start_ev = p_tick && (x == 12'd0) && (y == 12'(VD));
  assign abort_ev = p_tick && (x == 12'd0) && (y == 12'd0);

  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      idx_q         <= '0;
      tcnt_q        <= '0;
      ph_req_q      <= '0;
      busy_q        <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_cnt_q   <= '0;
      overrun_q     <= 1'b0;
      overrun_cnt_q <= '0;
      phase_err_q   <= '0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      tcnt_q        <= tcnt_d;
      ph_req_q      <= ph_req_d;
      busy_q        <= busy_d;
      frame_done_q  <= frame_done_d;
      frame_cnt_q   <= frame_cnt_d;
      overrun_q     <= overrun_d;
      overrun_cnt_q <= overrun_cnt_d;
      phase_err_q   <= phase_err_d;
    end
  end

  // Abort outranks done, and done outranks timeout in the same cycle.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    tcnt_d      = tcnt_q;
    timeout_hit = 1'b0;
    abort_hit   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_ev && !pause) begin
          state_d = S_REQ;
          idx_d   = '0;
          tcnt_d  = '0;
        end
      end
      S_REQ: begin
        if (abort_ev) begin
          state_d   = S_IDLE;
          abort_hit = 1'b1;
          idx_d     = '0;
          tcnt_d    = '0;
        end else if (ph_done[idx_q]) begin
          state_d = S_GAP;
          tcnt_d  = '0;
        end else if (tcnt_q == 16'(TIMEOUT - 1)) begin
          state_d     = S_GAP;
          timeout_hit = 1'b1;
          tcnt_d      = '0;
        end else begin
          tcnt_d = tcnt_q + 16'd1;
        end
      end
      S_GAP: begin
        tcnt_d = '0;
        if (abort_ev) begin
          state_d   = S_IDLE;
          abort_hit = 1'b1;
          idx_d     = '0;
        end else if (idx_q == IW'(N_PH - 1)) begin
          state_d = S_FIN;
        end else begin
          state_d = S_REQ;
          idx_d   = idx_q + IW'(1);
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
        idx_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
        idx_d   = '0;
        tcnt_d  = '0;
      end
    endcase
  end

  // Outputs are derived from the next state so they change on the same edge as the FSM.
  always_comb begin
    ph_req_d      = '0;
    busy_d        = (state_d != S_IDLE);
    frame_done_d  = (state_d == S_FIN);
    frame_cnt_d   = frame_cnt_q;
    overrun_d     = overrun_q;
    overrun_cnt_d = overrun_cnt_q;
    phase_err_d   = phase_err_q;
    if (state_d == S_REQ) begin
      ph_req_d = N_PH'(1) << idx_d;
    end
    if (state_d == S_FIN) begin
      frame_cnt_d = frame_cnt_q + 16'd1;
    end
    if (abort_hit) begin
      overrun_d = 1'b1;
      if (overrun_cnt_q != 8'hFF) begin
        overrun_cnt_d = overrun_cnt_q + 8'd1;
      end
    end
    if (timeout_hit) begin
      phase_err_d = phase_err_q | (N_PH'(1) << idx_q);
    end
    if (err_clr) begin
      overrun_d   = 1'b0;
      phase_err_d = '0;
    end
  end

  assign ph_req      = ph_req_q;
  assign busy        = busy_q;
  assign frame_done  = frame_done_q;
  assign frame_cnt   = frame_cnt_q;
  assign overrun     = overrun_q;
  assign overrun_cnt = overrun_cnt_q;
  assign phase_err   = phase_err_q;

endmodule

// File: tb/tb_frame_update_sequencer.sv
// tb/tb_frame_update_sequencer.sv - directed self-checking bench for frame_update_sequencer
module tb_frame_update_sequencer;

  localparam int N_PH = 4;
  localparam int VD   = 480;

  logic            clk_100MHz;
  logic            reset_n;
  logic            p_tick;
  logic [11:0]     x;
  logic [11:0]     y;
  logic            pause;
  logic [N_PH-1:0] ph_done;
  logic            err_clr;
  logic [N_PH-1:0] ph_req;
  logic            busy;
  logic            frame_done;
  logic [15:0]     frame_cnt;
  logic            overrun;
  logic [7:0]      overrun_cnt;
  logic [N_PH-1:0] phase_err;

  int n_asrt = 0;
  int n_fail = 0;
  int cnt;

  frame_update_sequencer #(.N_PH(N_PH), .VD(VD), .TIMEOUT(1000)) dut (
    .clk_100MHz (clk_100MHz),
    .reset_n    (reset_n),
    .p_tick     (p_tick),
    .x          (x),
    .y          (y),
    .pause      (pause),
    .ph_done    (ph_done),
    .err_clr    (err_clr),
    .ph_req     (ph_req),
    .busy       (busy),
    .frame_done (frame_done),
    .frame_cnt  (frame_cnt),
    .overrun    (overrun),
    .overrun_cnt(overrun_cnt),
    .phase_err  (phase_err)
  );

  initial clk_100MHz = 1'b0;
  always #5 clk_100MHz = ~clk_100MHz;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no finish, expected finish before 2ms");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_asrt++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk_100MHz);
    #1;
  endtask

  task automatic fire(input logic [11:0] yv);
    x = 12'd0;
    y = yv;
    p_tick = 1'b1;
    tick();
    p_tick = 1'b0;
    x = 12'd7;
    y = 12'd100;
  endtask

  // Req must be held for w cycles; done is returned in the last of them, then one gap cycle.
  task automatic phase(input int p, input int w);
    for (int i = 0; i < w; i++) begin
      chk($sformatf("req_ph%0d_c%0d", p, i), 32'(ph_req), 32'(1 << p));
      if (i == w - 1) ph_done = 4'(1 << p);
      tick();
    end
    ph_done = '0;
    chk($sformatf("gap_ph%0d", p), 32'(ph_req), 32'd0);
    chk($sformatf("gap_busy%0d", p), 32'(busy), 32'd1);
    tick();
  endtask

  task automatic fin(input logic [15:0] exp_cnt);
    chk("fin_done", 32'(frame_done), 32'd1);
    chk("fin_cnt", 32'(frame_cnt), 32'(exp_cnt));
    tick();
    chk("post_done", 32'(frame_done), 32'd0);
    chk("post_busy", 32'(busy), 32'd0);
  endtask

  task automatic fast_frame(input logic [15:0] exp_cnt);
    fire(12'(VD));
    for (int p = 0; p < N_PH; p++) phase(p, 1);
    fin(exp_cnt);
  endtask

  initial begin
    reset_n = 1'b0;
    p_tick  = 1'b0;
    x       = 12'd7;
    y       = 12'd100;
    pause   = 1'b0;
    ph_done = '0;
    err_clr = 1'b0;
    tick();
    tick();
    chk("rst_req", 32'(ph_req), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_cnt", 32'(frame_cnt), 32'd0);
    chk("rst_ovc", 32'(overrun_cnt), 32'd0);
    chk("rst_perr", 32'(phase_err), 32'd0);
    reset_n = 1'b1;
    tick();

    // Event position without p_tick must not start a frame
    x = 12'd0;
    y = 12'(VD);
    tick();
    x = 12'd7;
    y = 12'd100;
    chk("no_ptick_busy", 32'(busy), 32'd0);

    // Nominal frame, each phase acknowledged on its third req cycle
    fire(12'(VD));
    for (int p = 0; p < N_PH; p++) phase(p, 3);
    fin(16'd1);

    // Phase 2 times out after exactly 1000 req cycles
    fire(12'(VD));
    phase(0, 1);
    phase(1, 1);
    cnt = 0;
    while (ph_req[2] && cnt < 2000) begin
      cnt++;
      tick();
    end
    chk("timeout_len", 32'(cnt), 32'd1000);
    chk("timeout_perr", 32'(phase_err), 32'h4);
    chk("timeout_gap", 32'(ph_req), 32'd0);
    tick();
    phase(3, 1);
    fin(16'd2);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("errclr_perr", 32'(phase_err), 32'd0);

    // Stray dones in IDLE and on inactive phases are ignored
    ph_done = 4'hF;
    tick();
    tick();
    tick();
    chk("idle_done_busy", 32'(busy), 32'd0);
    chk("idle_done_req", 32'(ph_req), 32'd0);
    ph_done = '0;
    fire(12'(VD));
    ph_done = 4'h8;
    for (int i = 0; i < 4; i++) begin
      chk("stray_req", 32'(ph_req), 32'h1);
      tick();
    end
    phase(0, 1);
    for (int p = 1; p < N_PH; p++) phase(p, 1);
    fin(16'd3);

    // Paused frame
    pause = 1'b1;
    fire(12'(VD));
    chk("pause_busy", 32'(busy), 32'd0);
    chk("pause_req", 32'(ph_req), 32'd0);
    tick();
    pause = 1'b0;
    chk("pause_cnt", 32'(frame_cnt), 32'd3);

    // Active video restarts while phase 1 stalls
    fire(12'(VD));
    phase(0, 1);
    for (int i = 0; i < 20; i++) tick();
    chk("stall_req", 32'(ph_req), 32'h2);
    fire(12'd0);
    chk("abort_req", 32'(ph_req), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_ov", 32'(overrun), 32'd1);
    chk("abort_ovc", 32'(overrun_cnt), 32'd1);
    chk("abort_fcnt", 32'(frame_cnt), 32'd3);
    chk("abort_fdone", 32'(frame_done), 32'd0);
    fast_frame(16'd4);
    chk("ov_sticky", 32'(overrun), 32'd1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("ov_clr", 32'(overrun), 32'd0);
    chk("ovc_kept", 32'(overrun_cnt), 32'd1);

    // Abort coinciding with the active done: abort wins
    fire(12'(VD));
    ph_done = 4'h1;
    fire(12'd0);
    ph_done = '0;
    chk("simul_ov", 32'(overrun), 32'd1);
    chk("simul_busy", 32'(busy), 32'd0);
    chk("simul_ovc", 32'(overrun_cnt), 32'd2);
    chk("simul_fcnt", 32'(frame_cnt), 32'd4);

    // err_clr together with an abort leaves the flag cleared
    fire(12'(VD));
    err_clr = 1'b1;
    fire(12'd0);
    err_clr = 1'b0;
    chk("clr_beats_set", 32'(overrun), 32'd0);
    chk("clr_set_ovc", 32'(overrun_cnt), 32'd3);

    // Asynchronous reset mid-phase
    fire(12'(VD));
    phase(0, 1);
    tick();
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_req", 32'(ph_req), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_cnt", 32'(frame_cnt), 32'd0);
    chk("arst_ovc", 32'(overrun_cnt), 32'd0);
    @(posedge clk_100MHz);
    #1;
    reset_n = 1'b1;
    tick();
    chk("arst_idle", 32'(busy), 32'd0);
    fast_frame(16'd1);

    // Overrun counter saturation
    for (int i = 0; i < 254; i++) begin
      fire(12'(VD));
      fire(12'd0);
    end
    chk("ovc_254", 32'(overrun_cnt), 32'd254);
    for (int i = 0; i < 46; i++) begin
      fire(12'(VD));
      fire(12'd0);
    end
    chk("ovc_sat", 32'(overrun_cnt), 32'd255);
    chk("sat_fcnt", 32'(frame_cnt), 32'd1);

    // Frame counter wrap
    force dut.frame_cnt_q = 16'hFFFE;
    tick();
    release dut.frame_cnt_q;
    tick();
    fast_frame(16'hFFFF);
    fast_frame(16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
